// File: rtl/cpu_peripheral_bridge.sv
// cpu_peripheral_bridge
//   Bridges the CPU memory bus (valid/ready, request held by the CPU) to
//   CHANNELS peripheral channels. A request is registered, a channel is
//   picked from cpu_address[SEL_LSB +: SEL_W], and a valid/ready handshake
//   is held on that channel. Completion is a one-cycle cpu_mem_ready pulse
//   with registered read data. An unmapped channel number returns
//   TIMEOUT_DATA without touching any peripheral.
//
// Optional feature macro: BRIDGE_TIMEOUT_EN
//   When defined, a request left unanswered for TIMEOUT_CYCLES REQ cycles is
//   abandoned, answered with TIMEOUT_DATA, and the sticky timeout_flag is set
//   (cleared by timeout_clear; setting wins over a simultaneous clear).
//   When undefined, REQ waits forever and timeout_flag is constant 0.
//
// Ports
//   clk_2x          sole clock (posedge)
//   reset_n         synchronous active-low reset
//   cpu_mem_valid   CPU request, held until cpu_mem_ready is seen
//   cpu_address     request address
//   cpu_wstrb       byte strobes, 0 means read
//   cpu_write_data  write data
//   cpu_mem_ready   one-cycle completion pulse
//   cpu_read_data   read data, valid while cpu_mem_ready=1
//   per_valid       one-hot request to the selected channel
//   per_address     registered request address (shared)
//   per_wstrb       registered byte strobes (shared)
//   per_write_data  registered write data (shared)
//   per_ready       per-channel completion
//   per_read_data   channel c data at [c*DATA_WIDTH +: DATA_WIDTH]
//   timeout_clear   clears timeout_flag
//   timeout_flag    sticky timeout indicator
//   busy            high whenever the bridge is not idle
module cpu_peripheral_bridge #(
  parameter int ADDR_WIDTH     = 24,
  parameter int DATA_WIDTH     = 32,
  parameter int CHANNELS       = 4,
  parameter int SEL_LSB        = 20,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                           clk_2x,
  input  logic                           reset_n,
  input  logic                           cpu_mem_valid,
  input  logic [ADDR_WIDTH-1:0]          cpu_address,
  input  logic [DATA_WIDTH/8-1:0]        cpu_wstrb,
  input  logic [DATA_WIDTH-1:0]          cpu_write_data,
  output logic                           cpu_mem_ready,
  output logic [DATA_WIDTH-1:0]          cpu_read_data,
  output logic [CHANNELS-1:0]            per_valid,
  output logic [ADDR_WIDTH-1:0]          per_address,
  output logic [DATA_WIDTH/8-1:0]        per_wstrb,
  output logic [DATA_WIDTH-1:0]          per_write_data,
  input  logic [CHANNELS-1:0]            per_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] per_read_data,
  input  logic                           timeout_clear,
  output logic                           timeout_flag,
  output logic                           busy
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DROP} state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [CHANNELS-1:0]     per_valid_q, per_valid_d;
  logic [ADDR_WIDTH-1:0]   per_address_q, per_address_d;
  logic [STRB_W-1:0]       per_wstrb_q, per_wstrb_d;
  logic [DATA_WIDTH-1:0]   per_write_data_q, per_write_data_d;
  logic                    cpu_mem_ready_q, cpu_mem_ready_d;
  logic [DATA_WIDTH-1:0]   cpu_read_data_q, cpu_read_data_d;
  logic                    busy_q, busy_d;
  logic                    timeout_flag_q, timeout_flag_d;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_set;
`else
  // timeout_clear has no effect without the timeout feature.
  logic unused_timeout_clear;
  assign unused_timeout_clear = timeout_clear;
`endif

  // Channel decode of the incoming request and of the registered selection.
  logic [SEL_W-1:0]        sel_in;
  logic                    sel_in_mapped;
  logic [CHANNELS-1:0]     sel_in_onehot;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic [DATA_WIDTH-1:0]   ch_rdata [CHANNELS];

  assign sel_in        = cpu_address[SEL_LSB +: SEL_W];
  assign sel_in_mapped = (int'(sel_in) < CHANNELS);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    assign ch_rdata[gi]      = per_read_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign sel_in_onehot[gi] = (sel_in == SEL_W'(gi));
  end

  // Mux by comparison so a select value beyond CHANNELS never indexes out of range.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel_q == SEL_W'(c)) begin
        sel_ready = per_ready[c];
        sel_rdata = ch_rdata[c];
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    per_valid_d      = per_valid_q;
    per_address_d    = per_address_q;
    per_wstrb_d      = per_wstrb_q;
    per_write_data_d = per_write_data_q;
    cpu_mem_ready_d  = 1'b0;
    cpu_read_data_d  = cpu_read_data_q;
`ifdef BRIDGE_TIMEOUT_EN
    cnt_d            = cnt_q;
    timeout_set      = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (cpu_mem_valid) begin
          per_address_d    = cpu_address;
          per_wstrb_d      = cpu_wstrb;
          per_write_data_d = cpu_write_data;
          sel_d            = sel_in;
          if (sel_in_mapped) begin
            state_d     = S_REQ;
            per_valid_d = sel_in_onehot;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            // Unmapped: the pulse is raised from RESP one cycle later.
            state_d = S_RESP;
          end
        end
      end

      S_REQ: begin
        if (sel_ready) begin
          per_valid_d     = '0;
          cpu_read_data_d = sel_rdata;
          cpu_mem_ready_d = 1'b1;
          state_d         = S_RESP;
        end
`ifdef BRIDGE_TIMEOUT_EN
        // per_ready takes precedence over the timeout on the same edge.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          per_valid_d     = '0;
          cpu_read_data_d = TIMEOUT_DATA;
          cpu_mem_ready_d = 1'b1;
          timeout_set     = 1'b1;
          state_d         = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end

      S_RESP: begin
        // Mapped/timeout paths arrive with the pulse already raised; the
        // unmapped path arrives without it and raises it here.
        if (cpu_mem_ready_q) begin
          state_d = S_DROP;
        end else begin
          cpu_mem_ready_d = 1'b1;
          cpu_read_data_d = TIMEOUT_DATA;
        end
      end

      S_DROP: begin
        // Wait for the CPU to release its held request before re-arming.
        if (!cpu_mem_valid) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

`ifdef BRIDGE_TIMEOUT_EN
    if (timeout_set)        timeout_flag_d = 1'b1;
    else if (timeout_clear) timeout_flag_d = 1'b0;
    else                    timeout_flag_d = timeout_flag_q;
`else
    timeout_flag_d = 1'b0;
`endif
  end

  always_ff @(posedge clk_2x) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      sel_q            <= '0;
      per_valid_q      <= '0;
      per_address_q    <= '0;
      per_wstrb_q      <= '0;
      per_write_data_q <= '0;
      cpu_mem_ready_q  <= 1'b0;
      cpu_read_data_q  <= '0;
      busy_q           <= 1'b0;
      timeout_flag_q   <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q            <= '0;
`endif
    end else begin
      state_q          <= state_d;
      sel_q            <= sel_d;
      per_valid_q      <= per_valid_d;
      per_address_q    <= per_address_d;
      per_wstrb_q      <= per_wstrb_d;
      per_write_data_q <= per_write_data_d;
      cpu_mem_ready_q  <= cpu_mem_ready_d;
      cpu_read_data_q  <= cpu_read_data_d;
      busy_q           <= busy_d;
      timeout_flag_q   <= timeout_flag_d;
`ifdef BRIDGE_TIMEOUT_EN
      cnt_q            <= cnt_d;
`endif
    end
  end

  assign cpu_mem_ready  = cpu_mem_ready_q;
  assign cpu_read_data  = cpu_read_data_q;
  assign per_valid      = per_valid_q;
  assign per_address    = per_address_q;
  assign per_wstrb      = per_wstrb_q;
  assign per_write_data = per_write_data_q;
  assign busy           = busy_q;
  assign timeout_flag   = timeout_flag_q;

endmodule
